// File: rtl/bp_pkg.sv
// Shared types and helpers for the 2-bit saturating branch predictor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bp_pkg;

    // Counter encodings; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } sat2_t;

    localparam int unsigned MAX_INDEX_BITS = 8;

    // Step a 2-bit counter one position toward the resolved outcome, saturating at both ends.
    function automatic logic [1:0] sat2_next(input logic [1:0] state, input logic taken);
        logic [1:0] nxt;
        nxt = state;
        if (taken) begin
            if (state != ST) nxt = 2'(state + 2'd1);
        end else begin
            if (state != SNT) nxt = 2'(state - 2'd1);
        end
        return nxt;
    endfunction

    // Word-aligned PC bits select the entry; byte offset and upper bits are dropped, so aliasing is expected.
    function automatic logic [MAX_INDEX_BITS-1:0] bp_index(input logic [31:0] pc,
                                                           input int unsigned index_bits);
        logic [31:0] mask;
        mask = (32'd1 << index_bits) - 32'd1;
        return MAX_INDEX_BITS'((pc >> 2) & mask);
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Flop array of 2-bit saturating counters, one combinational read port, one training write port.
// Latency: read is combinational; a write becomes visible on the cycle after the edge (no bypass).
// Backpressure: none; a write is accepted every cycle wr_en is high.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = 4,
    parameter logic [1:0]  RESET_STATE = 2'b11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [1:0]            rd_dat,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_taken
);

    localparam int unsigned DEPTH = 1 << INDEX_BITS;

    logic [1:0] tbl [DEPTH];

    // Read returns the stored value, so a same-cycle write to the same entry is not forwarded.
    always_comb begin
        rd_dat = tbl[rd_idx];
    end

    // Reset every entry to the configured state; otherwise train the addressed entry.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl[i] <= RESET_STATE;
            end
        end else if (wr_en) begin
            tbl[wr_idx] <= sat2_next(tbl[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic 2-bit branch predictor: ID lookup, EX training, mispredict flag and perf counters.
// Latency: Predict_o and Wrong_predict_o are combinational; training lands on the next rising edge.
// Backpressure: none; one resolved branch is absorbed every cycle Branch_EX_i is high.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = 4,
    parameter logic [1:0]  RESET_STATE = 2'b11,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             Branch_ID_i,
    input  logic [31:0]      pc_ID_i,
    output logic             Predict_o,
    input  logic             Branch_EX_i,
    input  logic [31:0]      pc_EX_i,
    input  logic             Predict_EX_i,
    input  logic             Taken_EX_i,
    output logic             Wrong_predict_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    logic [INDEX_BITS-1:0] idx_id;
    logic [INDEX_BITS-1:0] idx_ex;
    logic [1:0]            rd_state;

    // Table indices for the ID lookup and the EX training write.
    always_comb begin
        idx_id = INDEX_BITS'(bp_index(pc_ID_i, INDEX_BITS));
        idx_ex = INDEX_BITS'(bp_index(pc_EX_i, INDEX_BITS));
    end

    bp_counter_table #(
        .INDEX_BITS  (INDEX_BITS),
        .RESET_STATE (RESET_STATE)
    ) u_table (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (idx_id),
        .rd_dat   (rd_state),
        .wr_en    (Branch_EX_i),
        .wr_idx   (idx_ex),
        .wr_taken (Taken_EX_i)
    );

    // Prediction is gated by the ID branch; mispredict compares the carried prediction, not the table.
    always_comb begin
        Predict_o       = Branch_ID_i & rd_state[1];
        Wrong_predict_o = Branch_EX_i & (Predict_EX_i != Taken_EX_i);
    end

    // Saturating counts of resolved branches and mispredictions since reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_o <= '0;
            miss_cnt_o   <= '0;
        end else if (Branch_EX_i) begin
            if (branch_cnt_o != '1) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            if (Wrong_predict_o && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor plus hand-written reset/saturation sequences.
// Latency: inputs change 1ns after a rising edge, outputs are sampled 1ns later.
// Backpressure: n/a.
module tb_branch_predictor;

    logic        clk_i;
    logic        rst_i;
    logic        branch_id;
    logic [31:0] pc_id;
    logic        branch_ex;
    logic [31:0] pc_ex;
    logic        predict_ex;
    logic        taken_ex;

    logic        predict;
    logic        wrong;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;
    logic        predict4;
    logic        wrong4;
    logic [3:0]  branch_cnt4;
    logic [3:0]  miss_cnt4;

    int n_vec;
    int n_err;

    branch_predictor dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .Branch_ID_i     (branch_id),
        .pc_ID_i         (pc_id),
        .Predict_o       (predict),
        .Branch_EX_i     (branch_ex),
        .pc_EX_i         (pc_ex),
        .Predict_EX_i    (predict_ex),
        .Taken_EX_i      (taken_ex),
        .Wrong_predict_o (wrong),
        .branch_cnt_o    (branch_cnt),
        .miss_cnt_o      (miss_cnt)
    );

    // Narrow-counter instance driven in lockstep to reach counter saturation quickly.
    branch_predictor #(.CNT_W(4)) dut4 (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .Branch_ID_i     (branch_id),
        .pc_ID_i         (pc_id),
        .Predict_o       (predict4),
        .Branch_EX_i     (branch_ex),
        .pc_EX_i         (pc_ex),
        .Predict_EX_i    (predict_ex),
        .Taken_EX_i      (taken_ex),
        .Wrong_predict_o (wrong4),
        .branch_cnt_o    (branch_cnt4),
        .miss_cnt_o      (miss_cnt4)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        bid;
        logic [31:0] pcid;
        logic        bex;
        logic [31:0] pcex;
        logic        pex;
        logic        tex;
        logic        exp_pred;
        logic        exp_wrong;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic bid, input logic [31:0] pcid,
                                input logic bex, input logic [31:0] pcex,
                                input logic pex, input logic tex,
                                input logic ep, input logic ew);
        vec_t v;
        v.bid = bid; v.pcid = pcid; v.bex = bex; v.pcex = pcex;
        v.pex = pex; v.tex = tex; v.exp_pred = ep; v.exp_wrong = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        branch_id  = 1'b0;
        pc_id      = 32'h0;
        branch_ex  = 1'b0;
        pc_ex      = 32'h0;
        predict_ex = 1'b0;
        taken_ex   = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Hand-computed trace starting from an all-ST table.
        // idx(0x10)=4, idx(0x14)=5, idx(0x20)=8, idx(0x30)=12, idx(0x50)=4 (alias of 0x10).
        vecs[0]  = mk(1, 32'h10, 0, 32'h0,  0, 0, 1, 0); // fresh table predicts taken
        vecs[1]  = mk(1, 32'h10, 1, 32'h10, 1, 0, 1, 1); // ST->WT, lookup sees ST
        vecs[2]  = mk(1, 32'h10, 1, 32'h10, 1, 0, 1, 1); // WT->WNT, lookup sees WT
        vecs[3]  = mk(1, 32'h10, 0, 32'h0,  0, 0, 0, 0); // now WNT
        vecs[4]  = mk(1, 32'h14, 0, 32'h0,  0, 0, 1, 0); // neighbour untouched
        vecs[5]  = mk(0, 32'h14, 0, 32'h0,  0, 0, 0, 0); // no ID branch -> 0
        vecs[6]  = mk(1, 32'h20, 1, 32'h20, 0, 0, 1, 0); // ST->WT
        vecs[7]  = mk(1, 32'h20, 1, 32'h20, 0, 0, 1, 0); // WT->WNT
        vecs[8]  = mk(1, 32'h20, 1, 32'h20, 0, 0, 0, 0); // WNT->SNT
        vecs[9]  = mk(1, 32'h20, 1, 32'h20, 0, 0, 0, 0); // SNT holds
        vecs[10] = mk(1, 32'h20, 1, 32'h20, 0, 0, 0, 0); // SNT holds
        vecs[11] = mk(1, 32'h20, 1, 32'h20, 0, 1, 0, 1); // SNT->WNT, mispredict
        vecs[12] = mk(1, 32'h20, 0, 32'h0,  0, 0, 0, 0); // WNT predicts not taken
        vecs[13] = mk(1, 32'h50, 0, 32'h0,  0, 0, 0, 0); // alias of 0x10 (WNT)
        vecs[14] = mk(1, 32'h0001_0013, 0, 32'h0, 0, 0, 0, 0); // upper/low bits ignored
        vecs[15] = mk(1, 32'h30, 1, 32'h30, 1, 0, 1, 1); // ST->WT, old value seen
        vecs[16] = mk(1, 32'h30, 1, 32'h30, 1, 0, 1, 1); // WT->WNT, old value seen
        vecs[17] = mk(1, 32'h30, 0, 32'h0,  0, 0, 0, 0); // new value WNT visible
        vecs[18] = mk(1, 32'h30, 1, 32'h30, 1, 1, 0, 0); // carried pred correct; WNT->WT
        vecs[19] = mk(1, 32'h30, 0, 32'h0,  0, 0, 1, 0); // WT
        vecs[20] = mk(1, 32'h30, 0, 32'h30, 1, 0, 1, 0); // no EX branch: no flag, no update
        vecs[21] = mk(1, 32'h30, 0, 32'h0,  0, 0, 1, 0); // still WT

        idle_inputs();
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Reset state.
        check("reset_branch_cnt", 32'(branch_cnt), 32'd0);
        check("reset_miss_cnt", 32'(miss_cnt), 32'd0);

        for (int i = 0; i < 22; i++) begin
            branch_id  = vecs[i].bid;
            pc_id      = vecs[i].pcid;
            branch_ex  = vecs[i].bex;
            pc_ex      = vecs[i].pcex;
            predict_ex = vecs[i].pex;
            taken_ex   = vecs[i].tex;
            #1;
            check($sformatf("vec%0d_predict", i), 32'(predict), 32'(vecs[i].exp_pred));
            check($sformatf("vec%0d_wrong", i), 32'(wrong), 32'(vecs[i].exp_wrong));
            next_cycle();
        end
        idle_inputs();
        #1;

        // 11 updates, 5 mispredicts in the trace above.
        check("trace_branch_cnt", 32'(branch_cnt), 32'd11);
        check("trace_miss_cnt", 32'(miss_cnt), 32'd5);
        check("trace_branch_cnt4", 32'(branch_cnt4), 32'd11);
        check("trace_miss_cnt4", 32'(miss_cnt4), 32'd5);

        // Asynchronous reset between edges, held across an edge with a would-be update.
        next_cycle();
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_branch_cnt", 32'(branch_cnt), 32'd0);
        check("async_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        branch_ex  = 1'b1;
        pc_ex      = 32'h10;
        predict_ex = 1'b1;
        taken_ex   = 1'b0;
        branch_id  = 1'b1;
        pc_id      = 32'h10;
        #1;
        check("rst_low_predict", 32'(predict), 32'd1);
        next_cycle();
        check("rst_low_no_update_cnt", 32'(branch_cnt), 32'd0);
        idle_inputs();
        rst_i = 1'b1;
        #1;

        // Every entry back to ST.
        for (int i = 0; i < 16; i++) begin
            branch_id = 1'b1;
            pc_id     = 32'(i * 4);
            #1;
            check($sformatf("reset_entry%0d", i), 32'(predict), 32'd1);
        end
        branch_id = 1'b0;
        #1;
        check("no_id_branch_predict", 32'(predict), 32'd0);

        // 20 correctly predicted taken branches: narrow counter saturates at F.
        branch_ex  = 1'b1;
        pc_ex      = 32'h40;
        predict_ex = 1'b1;
        taken_ex   = 1'b1;
        repeat (20) next_cycle();
        branch_ex = 1'b0;
        #1;
        check("sat_branch_cnt4", 32'(branch_cnt4), 32'hF);
        check("sat_branch_cnt16", 32'(branch_cnt), 32'd20);
        check("sat_miss_cnt", 32'(miss_cnt), 32'd0);

        // 17 mispredicts: narrow miss counter saturates too.
        branch_ex  = 1'b1;
        predict_ex = 1'b0;
        taken_ex   = 1'b1;
        repeat (17) next_cycle();
        branch_ex = 1'b0;
        #1;
        check("sat_miss_cnt4", 32'(miss_cnt4), 32'hF);
        check("sat_miss_cnt16", 32'(miss_cnt), 32'd17);
        check("sat_branch_cnt16_b", 32'(branch_cnt), 32'd37);
        check("sat_branch_cnt4_b", 32'(branch_cnt4), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
